// File: rtl/qu_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qu_common (package)
//  Purpose  : Shared widths, front-end queue defaults and the modular pointer
//             helper used by the queue, ROB and reservation-station logic.
//  Contents : QU_INSTR_WIDTH, QU_FEQ_DEPTH, QU_FEQ_ENQ_LANES,
//             QU_FEQ_DEQ_LANES, qu_wrap_add()
//  Revision : 1.0  initial release
// ============================================================================
package qu_common;

    localparam int unsigned QU_INSTR_WIDTH   = 32;
    localparam int unsigned QU_FEQ_DEPTH     = 16;
    localparam int unsigned QU_FEQ_ENQ_LANES = 2;
    localparam int unsigned QU_FEQ_DEQ_LANES = 2;

    // Modular pointer advance for any depth, power of two or not.
    // Callers guarantee ptr < depth and n <= depth, so one conditional
    // subtract is enough.
    function automatic int unsigned qu_wrap_add(input int unsigned ptr,
                                                input int unsigned n,
                                                input int unsigned depth);
        int unsigned sum;
        sum = ptr + n;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fe_queue_prefix_count.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_count
//  Purpose  : Counts the contiguous run of 1s starting at bit 0.
//  Ports    : bits  in  WIDTH              request vector, bit 0 oldest
//             count out $clog2(WIDTH+1)   length of the leading run of 1s
//  Revision : 1.0  initial release
// ============================================================================
module prefix_count #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0]         bits,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic w_run;

    always_comb begin
        w_run = 1'b1;
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Once a 0 is seen the run is broken and later 1s are ignored.
            w_run = w_run & bits[i];
            if (w_run) begin
                count = count + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fe_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fe_queue
//  Purpose  : Multi-lane in-order front-end queue, first-word-fall-through,
//             single-cycle flush, occupancy reporting for stall generation.
//  Ports    : clk, rst (async, active-low), flush
//             enq_valid/enq_data  in   up to ENQ_LANES pushes, lane 0 oldest
//             enq_ready           out  room for a full ENQ_LANES group
//             deq_valid/deq_data  out  head+0 .. head+DEQ_LANES-1
//             deq_pop             in   number of entries consumed
//             count/empty/full/almost_full  occupancy status
//             underflow_err       out  sticky, set when deq_pop > count
//  Revision : 1.0  initial release
// ============================================================================
module fe_queue
    import qu_common::*;
#(
    parameter int unsigned DATA_WIDTH   = QU_INSTR_WIDTH,
    parameter int unsigned DEPTH        = QU_FEQ_DEPTH,
    parameter int unsigned ENQ_LANES    = QU_FEQ_ENQ_LANES,
    parameter int unsigned DEQ_LANES    = QU_FEQ_DEQ_LANES,
    parameter int unsigned AF_THRESHOLD = DEPTH - ENQ_LANES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [ENQ_LANES-1:0]            enq_valid,
    input  logic [ENQ_LANES*DATA_WIDTH-1:0] enq_data,
    output logic                            enq_ready,
    output logic [DEQ_LANES-1:0]            deq_valid,
    output logic [DEQ_LANES*DATA_WIDTH-1:0] deq_data,
    input  logic [$clog2(DEQ_LANES+1)-1:0]  deq_pop,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_full,
    output logic                            underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENQ_W = $clog2(ENQ_LANES + 1);

    localparam logic [CNT_W-1:0] C_ENQ_LIMIT = CNT_W'(DEPTH - ENQ_LANES);
    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_underflow;

    logic [ENQ_W-1:0]      w_run_len;
    logic [ENQ_W-1:0]      w_n_enq;
    logic [CNT_W-1:0]      w_pop_req;
    logic [CNT_W-1:0]      w_n_pop;
    logic                  w_underflow;

    // ---------------------------------------------------------------------
    // Push / pop counts
    // ---------------------------------------------------------------------
    prefix_count #(
        .WIDTH (ENQ_LANES)
    ) u_prefix_count (
        .bits  (enq_valid),
        .count (w_run_len)
    );

    // Ready looks at registered occupancy only, so a same-cycle pop can
    // never open the door for a push (no deq_pop -> enq_ready path).
    assign enq_ready   = (r_count <= C_ENQ_LIMIT);
    assign w_n_enq     = enq_ready ? w_run_len : '0;

    assign w_pop_req   = CNT_W'(deq_pop);
    assign w_underflow = (w_pop_req > r_count);
    assign w_n_pop     = w_underflow ? r_count : w_pop_req;

    // ---------------------------------------------------------------------
    // Pointer, count and sticky error state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_head      <= PTR_W'(qu_wrap_add(32'(r_head), 32'(w_n_pop), DEPTH));
            r_tail      <= PTR_W'(qu_wrap_add(32'(r_tail), 32'(w_n_enq), DEPTH));
            r_count     <= r_count + CNT_W'(w_n_enq) - w_n_pop;
            r_underflow <= r_underflow | w_underflow;
        end
    end

    // ---------------------------------------------------------------------
    // Storage: ENQ_LANES write ports, no reset on the data array
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_LANES; i++) begin
            if (!flush && (ENQ_W'(i) < w_n_enq)) begin
                r_mem[PTR_W'(qu_wrap_add(32'(r_tail), unsigned'(i), DEPTH))]
                    <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Dequeue read ports: data forced to zero on lanes without an entry
    // ---------------------------------------------------------------------
    generate
        for (genvar g = 0; g < DEQ_LANES; g++) begin : g_deq
            logic [PTR_W-1:0] w_rd_idx;
            assign w_rd_idx     = PTR_W'(qu_wrap_add(32'(r_head), g, DEPTH));
            assign deq_valid[g] = (r_count > CNT_W'(g));
            assign deq_data[g*DATA_WIDTH +: DATA_WIDTH] =
                deq_valid[g] ? r_mem[w_rd_idx] : '0;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Status
    // ---------------------------------------------------------------------
    assign count         = r_count;
    assign empty         = (r_count == '0);
    assign full          = (r_count == C_DEPTH);
    assign almost_full   = (32'(r_count) >= AF_THRESHOLD);
    assign underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: doc/fe_queue.md
# fe_queue

Parametrised multi-lane front-end queue. It is the successor to the single-lane `fifo` between front-end stages (IF→ID, ID→MP, MP→RN). Each cycle it accepts up to ENQ_LANES entries and releases up to DEQ_LANES entries, in order. A single-cycle flush empties it for branch, jump and exception redirects. Data is first-word-fall-through, and occupancy is reported for stall generation.

## Interface
Parameters:
- DATA_WIDTH, default QU_INSTR_WIDTH: entry width in bits (set to UOP_WIDTH for uop queues).
- DEPTH, default 16: number of entries; need not be a power of two; must be ≥ 2*max(ENQ_LANES, DEQ_LANES).
- ENQ_LANES, default 2: maximum pushes per cycle, ≥ 1.
- DEQ_LANES, default 2: maximum pops per cycle, ≥ 1.
- AF_THRESHOLD, default DEPTH-ENQ_LANES: `almost_full` asserts when count ≥ this value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all contents.
- enq_valid  in  ENQ_LANES  per-lane push request; lane 0 is oldest.
- enq_data  in  ENQ_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- enq_ready  out  1  queue can take a full ENQ_LANES group this cycle.
- deq_valid  out  DEQ_LANES  lane i holds a valid entry.
- deq_data  out  DEQ_LANES*DATA_WIDTH  entries head+0 through head+DEQ_LANES-1.
- deq_pop  in  $clog2(DEQ_LANES+1)  number of entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESHOLD.
- underflow_err  out  1  sticky; set when deq_pop > count.

## Operation
- **Push count (n_enq).** n_enq is the length of the contiguous run of 1s in enq_valid starting at lane 0. Lanes after the first 0 are ignored. n_enq is 0 when enq_ready is low.
- **Push write.** Accepted lane i is written to storage[tail ⊕ i], where ⊕ is addition modulo DEPTH.
- **enq_ready.** enq_ready = (DEPTH − count ≥ ENQ_LANES). It uses registered count only; same-cycle pops do not raise it, so there is no deq_pop→enq_ready path.
- **Pop count (n_pop).** n_pop = min(deq_pop, count). If deq_pop > count, underflow_err sets and only count entries are popped.
- **Dequeue outputs.** deq_valid[i] = (count > i). deq_data lane i = storage[head ⊕ i] when deq_valid[i], else all zeros.
- **Pointer and count update.**
  - head ← head ⊕ n_pop.
  - tail ← tail ⊕ n_enq.
  - count ← count + n_enq − n_pop.
  - Modular add: sum = ptr + n; if sum ≥ DEPTH, subtract DEPTH. No reliance on power-of-two overflow.
- **Flush.**
  - Priority over push and pop in the same cycle.
  - head, tail and count go to 0; same-cycle enq and pop are discarded.
  - underflow_err is cleared.
  - Storage contents are not cleared.
- **Reset** (rst = 0, asynchronous):
  - head = tail = count = 0; underflow_err = 0.
  - Outputs: empty = 1, full = 0, almost_full = 0 (for AF_THRESHOLD > 0), enq_ready = 1, deq_valid = 0, deq_data = 0.
  - Storage is not reset. Deassertion takes effect at the next clk edge.
- **Simultaneous push/pop.**
  - When full, pops are allowed and pushes are refused.
  - When empty, a push is not visible on deq until the next cycle; there is no bypass.

## Timing
- Enqueue-to-dequeue latency is 1 cycle: data pushed at edge t appears on deq_valid/deq_data after edge t.
- deq_valid, deq_data, count, empty, full, almost_full and enq_ready are functions of registered state only.
- The only combinational input→state paths are deq_pop and enq_valid into the next-state logic.
- Flush asserted at edge t gives empty = 1 after t.
- Sustained throughput is min(ENQ_LANES, DEQ_LANES) entries per cycle while count ≤ DEPTH − ENQ_LANES.

## Structure
- Add to qu_common: QU_FEQ_DEPTH, QU_FEQ_ENQ_LANES, QU_FEQ_DEQ_LANES, and a function `qu_wrap_add(ptr, n, depth)` for modular pointer addition, which is shared with ROB and reservation-station logic.
- One sub-module: `prefix_count`, parametrised by width. It returns the number of contiguous 1s from bit 0 and is used for n_enq.
- Storage is a DEPTH×DATA_WIDTH register array with ENQ_LANES write ports and DEQ_LANES read ports.

## Test plan
Bench configuration: DATA_WIDTH=32, DEPTH=8, ENQ_LANES=2, DEQ_LANES=2.
- **Reset:** rst = 0 mid-stream with count = 5 → asynchronously count = 0, empty = 1, enq_ready = 1, deq_valid = 00, deq_data = 0.
- **Fill/drain:** push pairs {A0,A1} through {A6,A7} with deq_pop = 0 → after 4 edges count = 8, full = 1, enq_ready = 0. Then deq_pop = 2 for 4 cycles → lanes read A0/A1 … A6/A7 in order, then empty = 1.
- **Wrap-around:**
  - push 6 entries, pop 6, push {B0,B1,B2,B3} → head = tail start at 6; B2 is stored at index 0.
  - deq lane 0 = B0, lane 1 = B1, then B2, B3.
- **Non-contiguous valid / underflow:**
  - enq_valid = 10 → nothing written, count unchanged.
  - With count = 1, deq_pop = 2 → count = 0 and underflow_err = 1, held until flush.
- **Simultaneous push/pop with flush:**
  - count = 6, enq_valid = 11, deq_pop = 2 → count stays 6, enq_ready = 1 (DEPTH − count = 2).
  - Next cycle flush = 1 with enq_valid = 11 → count = 0, nothing enqueued, underflow_err = 0.
- **Ready without combinational pop:** count = 7, deq_pop = 2 → enq_ready = 0 that cycle, 1 the next (count = 5).
